// File: rtl/peridot_servo_pkg.sv
// peridot_servo_pkg: shared widths, timing constants and FSM states for the servo peripheral.
package peridot_servo_pkg;
    localparam int STEPW = 13;
    localparam int FRAMESTEP = 2560;
    localparam int DEF_MINWIDTHSTEP = 64;
    localparam logic [7:0] WIDTH_RESET = 8'd128;
    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_RISE, MEASURE} cap_state_t;
endpackage

// File: rtl/peridot_servo_insync.sv
// peridot_servo_insync: two-flop synchroniser plus history flop with edge detect.
module peridot_servo_insync (
    input  logic clock_sig,
    input  logic reset_sig,
    input  logic async_in,
    output logic s_in,
    output logic rise,
    output logic fall
);
    logic meta;
    logic s_prev;
    always_ff @(posedge clock_sig or posedge reset_sig)
        if (reset_sig) begin
            meta   <= 1'b0;
            s_in   <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            meta   <= async_in;
            s_in   <= meta;
            s_prev <= s_in;
        end
    assign rise = s_in & ~s_prev;
    assign fall = ~s_in & s_prev;
endmodule

// File: rtl/peridot_servo_pwmcap.sv
// peridot_servo_pwmcap: measures servo pulse high time in PWM steps and decodes it
// back into the 8-bit width code, with validity, timeout and sticky error reporting.
module peridot_servo_pwmcap
    import peridot_servo_pkg::*;
#(
    parameter int MINWIDTHSTEP = DEF_MINWIDTHSTEP,
    parameter int MAXPULSESTEP = 640,
    parameter int TIMEOUTSTEP  = 5120
) (
    input  logic       clock_sig,
    input  logic       reset_sig,
    input  logic       cap_enable,
    input  logic       step_tick,
    input  logic       pwm_in,
    input  logic       err_clear,
    output logic [7:0] reg_readdata,
    output logic       cap_valid,
    output logic       cap_update,
    output logic       cap_timeout,
    output logic       cap_error
);
    localparam logic [STEPW-1:0] MINW   = STEPW'(MINWIDTHSTEP);
    localparam logic [STEPW-1:0] MAXP   = STEPW'(MAXPULSESTEP);
    localparam logic [STEPW-1:0] TMO    = STEPW'(TIMEOUTSTEP);
    localparam logic [STEPW-1:0] TMO_M1 = STEPW'(TIMEOUTSTEP - 1);
    localparam logic [STEPW-1:0] CODE_MAX = STEPW'(255);

    cap_state_t       state;
    logic [STEPW-1:0] step_cnt;
    logic [STEPW-1:0] tmo_cnt;
    logic [STEPW-1:0] diff;
    logic [7:0]       code;
    logic             s_in;
    logic             rise;
    logic             fall;

    peridot_servo_insync u_sync (
        .clock_sig(clock_sig),
        .reset_sig(reset_sig),
        .async_in (pwm_in),
        .s_in     (s_in),
        .rise     (rise),
        .fall     (fall)
    );

    // underflow is guarded explicitly so a short pulse never decodes from a wrapped value
    assign diff = step_cnt - MINW;
    assign code = (step_cnt < MINW) ? 8'd0 : (diff > CODE_MAX) ? 8'd255 : diff[7:0];

    always_ff @(posedge clock_sig or posedge reset_sig)
        if (reset_sig) begin
            state        <= IDLE;
            step_cnt     <= '0;
            tmo_cnt      <= '0;
            reg_readdata <= WIDTH_RESET;
            cap_valid    <= 1'b0;
            cap_update   <= 1'b0;
            cap_timeout  <= 1'b0;
            cap_error    <= 1'b0;
        end else begin
            cap_update <= 1'b0;
            if (err_clear)
                cap_error <= 1'b0;
            if (!cap_enable) begin
                state     <= IDLE;
                cap_valid <= 1'b0;
                step_cnt  <= '0;
                tmo_cnt   <= '0;
            end else begin
                if (state != IDLE && step_tick && tmo_cnt < TMO) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_cnt == TMO_M1) begin
                        cap_timeout <= 1'b1;
                        cap_valid   <= 1'b0;
                    end
                end
                // later assignments below let a capture override a coincident timeout
                case (state)
                    IDLE:      state <= WAIT_LOW;
                    WAIT_LOW:  if (!s_in) state <= WAIT_RISE;
                    WAIT_RISE: if (rise) begin
                        step_cnt <= '0;
                        state    <= MEASURE;
                    end
                    MEASURE: begin
                        if (step_cnt > MAXP) begin
                            cap_error <= 1'b1;
                            state     <= WAIT_LOW;
                        end else if (fall) begin
                            reg_readdata <= code;
                            cap_update   <= 1'b1;
                            cap_valid    <= 1'b1;
                            cap_timeout  <= 1'b0;
                            tmo_cnt      <= '0;
                            state        <= WAIT_RISE;
                        end else if (s_in && step_tick)
                            step_cnt <= step_cnt + 1'b1;
                    end
                    default:   state <= IDLE;
                endcase
            end
        end
endmodule

// File: tb/tb_peridot_servo_pwmcap.sv
// tb_peridot_servo_pwmcap: scoreboard bench; pulses of known step length are issued and
// a monitor compares every cap_update against the code expected from the pulse length.
module tb_peridot_servo_pwmcap;
    logic       clock_sig = 1'b0;
    logic       reset_sig = 1'b1;
    logic       cap_enable = 1'b0;
    logic       step_tick = 1'b0;
    logic       pwm_in = 1'b0;
    logic       err_clear = 1'b0;
    logic [7:0] reg_readdata;
    logic       cap_valid;
    logic       cap_update;
    logic       cap_timeout;
    logic       cap_error;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_code = 8'd128;

    peridot_servo_pwmcap dut (
        .clock_sig   (clock_sig),
        .reset_sig   (reset_sig),
        .cap_enable  (cap_enable),
        .step_tick   (step_tick),
        .pwm_in      (pwm_in),
        .err_clear   (err_clear),
        .reg_readdata(reg_readdata),
        .cap_valid   (cap_valid),
        .cap_update  (cap_update),
        .cap_timeout (cap_timeout),
        .cap_error   (cap_error)
    );

    always #5 clock_sig = ~clock_sig;

    initial forever begin
        @(posedge clock_sig);
        #1;
        cyc++;
        step_tick = (cyc % 4 == 0);
    end

    function automatic logic [7:0] code_of(input int n);
        if (n < 64) return 8'd0;
        if (n - 64 > 255) return 8'd255;
        return 8'(n - 64);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clock_sig);
            #2;
        end
    endtask

    task automatic align;
        do cyc_wait(1); while (cyc % 4 != 0);
    endtask

    // a pulse of n steps: pin high for exactly 4n clocks, starting just after a tick
    task automatic pulse(input int n);
        align();
        if (n <= 640) begin
            exp_q.push_back(code_of(n));
            last_code = code_of(n);
        end
        pwm_in = 1'b1;
        cyc_wait(4 * n);
        pwm_in = 1'b0;
        cyc_wait(40);
    endtask

    initial forever begin
        @(negedge clock_sig);
        if (!reset_sig && cap_update) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_update: got code %0d expected no update", reg_readdata);
            end else begin
                check("update_code", reg_readdata, exp_q.pop_front());
                check("update_valid", cap_valid, 1);
                check("update_timeout", cap_timeout, 0);
            end
        end
    end

    initial begin
        int n;
        cyc_wait(3);
        check("rst_data", reg_readdata, 128);
        check("rst_valid", cap_valid, 0);
        check("rst_update", cap_update, 0);
        check("rst_timeout", cap_timeout, 0);
        check("rst_error", cap_error, 0);
        reset_sig = 1'b0;
        cyc_wait(2);
        cap_enable = 1'b1;
        cyc_wait(8);
        pulse(192);
        check("first_valid", cap_valid, 1);
        check("first_data", reg_readdata, 128);
        pulse(50);
        pulse(400);
        pulse(64);
        pulse(65);
        pulse(640);
        pulse(63);
        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(1, 640);
            pulse(n);
            check("rand_data", reg_readdata, last_code);
        end
        // stuck-high pin: error at 641 steps, no capture
        pulse(700);
        check("stuck_error", cap_error, 1);
        check("stuck_data", reg_readdata, last_code);
        err_clear = 1'b1;
        cyc_wait(1);
        err_clear = 1'b0;
        cyc_wait(1);
        check("err_clear", cap_error, 0);
        pulse(192);
        cyc_wait(4 * 5000);
        check("pre_tmo_valid", cap_valid, 1);
        check("pre_tmo_flag", cap_timeout, 0);
        cyc_wait(4 * 130);
        check("tmo_valid", cap_valid, 0);
        check("tmo_flag", cap_timeout, 1);
        check("tmo_data", reg_readdata, 128);
        pulse(192);
        check("post_tmo_flag", cap_timeout, 0);
        check("post_tmo_valid", cap_valid, 1);
        cap_enable = 1'b0;
        cyc_wait(4);
        check("disabled_valid", cap_valid, 0);
        pwm_in = 1'b1;
        cyc_wait(80);
        cap_enable = 1'b1;
        cyc_wait(120);
        pwm_in = 1'b0;
        cyc_wait(40);
        pulse(256);
        check("late_enable_data", reg_readdata, 192);
        align();
        pwm_in = 1'b1;
        cyc_wait(400);
        cap_enable = 1'b0;
        cyc_wait(20);
        pwm_in = 1'b0;
        cyc_wait(20);
        check("abort_valid", cap_valid, 0);
        check("abort_data", reg_readdata, 192);
        cap_enable = 1'b1;
        cyc_wait(8);
        pulse(192);
        check("reenable_data", reg_readdata, 128);
        pulse(700);
        check("stuck2_error", cap_error, 1);
        pulse(100);
        check("pre_reset_data", reg_readdata, 36);
        align();
        pwm_in = 1'b1;
        cyc_wait(200);
        reset_sig = 1'b1;
        #1;
        check("async_rst_data", reg_readdata, 128);
        check("async_rst_valid", cap_valid, 0);
        check("async_rst_update", cap_update, 0);
        check("async_rst_timeout", cap_timeout, 0);
        check("async_rst_error", cap_error, 0);
        pwm_in = 1'b0;
        exp_q.delete();
        cyc_wait(4);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
